// File: rtl/dcache_port.sv
// Blocking data-cache port: turns M-stage loads/stores into single-word memory requests.
// Optional one-entry line buffer enabled by defining DCACHE_LINE_BUF_EN.
module dcache_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_DOUT     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic [1:0]  cpu_st_size,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [29:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    mask_q, mask_d;
  logic          rw_q, rw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dout_q, dout_d;
  logic          err_q, err_d;

  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic          st_misaligned;
  logic [CW-1:0] cnt_inc;
  logic          rd_done;
  logic          rd_timeout;
  logic          rd_hit;
  logic [31:0]   rd_hit_data;

  // Store lane formatting; size 11 behaves as a word store.
  always_comb begin
    st_mask       = 4'b1111;
    st_data       = cpu_din;
    st_misaligned = 1'b0;
    case (cpu_st_size)
      2'b00: begin
        st_mask = 4'b0001 << cpu_addr[1:0];
        st_data = {4{cpu_din[7:0]}};
      end
      2'b01: begin
        st_mask       = cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_data       = {2{cpu_din[15:0]}};
        st_misaligned = cpu_addr[0];
      end
      default: begin
        st_mask       = 4'b1111;
        st_data       = cpu_din;
        st_misaligned = |cpu_addr[1:0];
      end
    endcase
  end

  assign cnt_inc    = cnt_q + 1'b1;
  assign rd_done    = (state_q == S_WAIT) && mem_resp_valid;
  assign rd_timeout = (state_q == S_WAIT) && !mem_resp_valid && (cnt_inc == CW'(TIMEOUT_CYCLES));

`ifdef DCACHE_LINE_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_merged;
  logic        buf_match;

  assign buf_match   = buf_valid_q && (buf_addr_q == cpu_addr[31:2]);
  assign rd_hit      = buf_match;
  assign rd_hit_data = buf_data_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign buf_merged[8*gi +: 8] = st_mask[gi] ? st_data[8*gi +: 8] : buf_data_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if ((state_q == S_IDLE) && cpu_we && !st_misaligned && buf_match) begin
      buf_data_d = buf_merged;
    end else if (rd_done) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = addr_q;
      buf_data_d  = mem_resp_data;
    end else if (rd_timeout) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign rd_hit      = 1'b0;
  assign rd_hit_data = 32'h0000_0000;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Write wins when both requests are raised together.
        if (cpu_we) begin
          if (st_misaligned) begin
            err_d = 1'b1;
          end else begin
            addr_d  = cpu_addr[31:2];
            data_d  = st_data;
            mask_d  = st_mask;
            rw_d    = 1'b1;
            state_d = S_REQ;
          end
        end else if (cpu_re) begin
          if (rd_hit) begin
            dout_d = rd_hit_data;
          end else begin
            addr_d  = cpu_addr[31:2];
            data_d  = 32'h0000_0000;
            mask_d  = 4'b0000;
            rw_d    = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (rw_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (rd_done) begin
          dout_d  = mem_resp_data;
          state_d = S_IDLE;
        end else if (rd_timeout) begin
          dout_d  = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= RESET_DOUT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign cpu_stall     = (state_q != S_IDLE);
  assign cpu_err       = err_q;
  assign cpu_dout      = dout_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign mem_req_mask  = mask_q;

endmodule

// File: tb/tb_dcache_port.sv
// Scoreboard bench for dcache_port: stimulus queues expected requests/errors/load data,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dcache_port;

  localparam logic [31:0] RST_DOUT = 32'h5A5A_0001;

  logic        clk;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_din;
  logic [1:0]  cpu_st_size;
  logic [31:0] cpu_dout;
  logic        cpu_stall, cpu_err;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dcache_port #(.TIMEOUT_CYCLES(4), .RESET_DOUT(RST_DOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_st_size(cpu_st_size), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  typedef struct packed {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_dout[$];
  int          exp_err[$];

  int tests = 0;
  int fails = 0;
  int stall_cycles = 0;
  logic prev_stall = 1'b0;
  logic pending_read = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: compares DUT-presented events against the scoreboard queues.
  always @(negedge clk) begin
    if (cpu_stall) stall_cycles++;
    if (!reset) begin
      pending_read = 1'b0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got rw=%0b addr=%0h data=%0h mask=%b required none",
                   mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          check("req_rw_mask", {59'd0, mem_req_rw, mem_req_mask}, {59'd0, e.rw, e.mask});
          check("req_addr", {34'd0, mem_req_addr}, {34'd0, e.addr});
          check("req_data", {32'd0, mem_req_data}, {32'd0, e.data});
          if (!mem_req_rw) pending_read = 1'b1;
        end
      end
      if (cpu_err) begin
        if (exp_err.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_err: got cpu_err=1 required 0");
        end else begin
          void'(exp_err.pop_front());
          check("err_pulse", {63'd0, cpu_err}, 64'd1);
        end
      end
      if (prev_stall && !cpu_stall && pending_read) begin
        pending_read = 1'b0;
        if (exp_dout.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_load: got dout=%0h required none", cpu_dout);
        end else begin
          logic [31:0] d;
          d = exp_dout.pop_front();
          check("load_dout", {32'd0, cpu_dout}, {32'd0, d});
        end
      end
    end
    prev_stall = cpu_stall;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read with ready=1; response on WAIT cycle resp_cycle (0 = never respond).
  task automatic read_txn(input logic [31:0] addr, input int resp_cycle, input logic [31:0] rdata,
                          input int exp_stall);
    int s0;
    int g;
    s0 = stall_cycles;
    cpu_re = 1'b1; cpu_addr = addr; mem_req_ready = 1'b1;
    tick();
    cpu_re = 1'b0;
    tick();
    for (int w = 1; w < resp_cycle; w++) tick();
    if (resp_cycle > 0) begin
      mem_resp_valid = 1'b1; mem_resp_data = rdata;
      tick();
      mem_resp_valid = 1'b0;
    end
    g = 0;
    while (cpu_stall && g < 50) begin tick(); g++; end
    tick();
    mem_req_ready = 1'b0;
    check("read_stall_cycles", 64'(stall_cycles - s0), 64'(exp_stall));
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] din, input logic [1:0] size,
                           input logic also_re);
    int s0;
    s0 = stall_cycles;
    cpu_we = 1'b1; cpu_re = also_re; cpu_addr = addr; cpu_din = din; cpu_st_size = size;
    mem_req_ready = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
    tick();
    check("write_stall_cycles", 64'(stall_cycles - s0), 64'd1);
  endtask

  initial begin
    int s0;
    reset = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_st_size = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    check("rst_stall_err", {62'd0, cpu_stall, cpu_err}, 64'd0);
    check("rst_req", {mem_req_valid, mem_req_rw, mem_req_mask, mem_req_addr}, 64'd0);
    check("rst_req_data", {32'd0, mem_req_data}, 64'd0);
    check("rst_dout", {32'd0, cpu_dout}, {32'd0, RST_DOUT});
    reset = 1'b1;
    tick();

    // Load 0x100, response on third WAIT cycle.
    exp_req.push_back('{1'b0, 30'h40, 32'h0, 4'b0000});
    exp_dout.push_back(32'h1234_5678);
    read_txn(32'h100, 3, 32'h1234_5678, 4);

    // Response outside WAIT is ignored.
    mem_resp_valid = 1'b1; mem_resp_data = 32'h9999_9999;
    tick(); tick();
    mem_resp_valid = 1'b0;
    check("resp_idle_ignored", {32'd0, cpu_dout}, 64'h1234_5678);

    // Byte store at 0x203 with ready held low for 5 cycles.
    exp_req.push_back('{1'b1, 30'h80, 32'hABAB_ABAB, 4'b1000});
    s0 = stall_cycles;
    cpu_we = 1'b1; cpu_addr = 32'h203; cpu_din = 32'h0000_00AB; cpu_st_size = 2'b00;
    mem_req_ready = 1'b0;
    tick();
    cpu_we = 1'b0; cpu_din = 32'hFFFF_FFFF; cpu_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("st_hold_ctl", {mem_req_valid, mem_req_rw, mem_req_mask, mem_req_addr},
            {28'd0, 1'b1, 1'b1, 4'b1000, 30'h80});
      check("st_hold_data", {32'd0, mem_req_data}, 64'hABAB_ABAB);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("st_hold_stall_cycles", 64'(stall_cycles - s0), 64'd6);

    // Misaligned half store: dropped with an error pulse.
    exp_err.push_back(1);
    s0 = stall_cycles;
    cpu_we = 1'b1; cpu_addr = 32'h101; cpu_din = 32'h1234; cpu_st_size = 2'b01;
    mem_req_ready = 1'b1;
    tick();
    cpu_we = 1'b0;
    check("misalign_no_req", {62'd0, mem_req_valid, cpu_stall}, 64'd0);
    tick(); tick();
    mem_req_ready = 1'b0;
    check("misalign_stall_cycles", 64'(stall_cycles - s0), 64'd0);

    // Misaligned word store.
    exp_err.push_back(1);
    cpu_we = 1'b1; cpu_addr = 32'h106; cpu_st_size = 2'b10;
    tick();
    cpu_we = 1'b0;
    tick();

    // Back-to-back aligned stores of each size, and write-wins over read.
    exp_req.push_back('{1'b1, 30'h40, 32'hBEEF_BEEF, 4'b1100});
    write_txn(32'h102, 32'h1234_BEEF, 2'b01, 1'b0);
    exp_req.push_back('{1'b1, 30'h41, 32'hCAFE_F00D, 4'b1111});
    write_txn(32'h104, 32'hCAFE_F00D, 2'b10, 1'b0);
    exp_req.push_back('{1'b1, 30'h42, 32'h0102_0304, 4'b1111});
    write_txn(32'h108, 32'h0102_0304, 2'b11, 1'b1);
    exp_req.push_back('{1'b1, 30'h43, 32'h5555_5555, 4'b0010});
    write_txn(32'h10D, 32'h0000_0055, 2'b00, 1'b0);

    // Read timeout after 4 WAIT cycles.
    exp_req.push_back('{1'b0, 30'h80, 32'h0, 4'b0000});
    exp_err.push_back(1);
    exp_dout.push_back(32'hDEAD_BEEF);
    read_txn(32'h200, 0, 32'h0, 5);

    // Reset during WAIT abandons the read; later response ignored.
    exp_req.push_back('{1'b0, 30'hC0, 32'h0, 4'b0000});
    cpu_re = 1'b1; cpu_addr = 32'h300; mem_req_ready = 1'b1;
    tick();
    cpu_re = 1'b0;
    tick(); tick();
    mem_req_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rstwait_idle", {62'd0, mem_req_valid, cpu_stall}, 64'd0);
    check("rstwait_dout", {32'd0, cpu_dout}, {32'd0, RST_DOUT});
    mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
    tick(); tick();
    mem_resp_valid = 1'b0;
    check("rstwait_resp_ignored", {32'd0, cpu_dout}, {32'd0, RST_DOUT});

`ifdef DCACHE_LINE_BUF_EN
    // Buffer: load, store-merge, then hit with no memory read.
    exp_req.push_back('{1'b0, 30'h40, 32'h0, 4'b0000});
    exp_dout.push_back(32'h1122_3344);
    read_txn(32'h100, 1, 32'h1122_3344, 2);
    exp_req.push_back('{1'b1, 30'h40, 32'hFFFF_FFFF, 4'b0001});
    write_txn(32'h100, 32'h0000_00FF, 2'b00, 1'b0);
    cpu_re = 1'b1; cpu_addr = 32'h100; mem_req_ready = 1'b1;
    tick();
    cpu_re = 1'b0;
    check("buf_hit_no_stall", {63'd0, cpu_stall}, 64'd0);
    check("buf_hit_dout", {32'd0, cpu_dout}, 64'h1122_33FF);
    tick(); tick();
    mem_req_ready = 1'b0;
`endif

    tick(); tick();
    check("req_queue_drained", 64'(exp_req.size()), 64'd0);
    check("err_queue_drained", 64'(exp_err.size()), 64'd0);
    check("dout_queue_drained", 64'(exp_dout.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_port.md
DCACHE_PORT -- requirements
Module: dcache_port

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles before a read is abandoned.
REQ-002 Parameter RESET_DOUT, default 32'h0000_0000: value of cpu_dout after reset.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; 0 sampled at a clk rising edge resets the block.
REQ-005 cpu_re  in  1  load request from the pipeline M stage.
REQ-006 cpu_we  in  1  store request from the pipeline M stage.
REQ-007 cpu_addr  in  32  byte address.
REQ-008 cpu_din  in  32  store data, right-aligned.
REQ-009 cpu_st_size  in  2  store size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-010 cpu_dout  out  32  registered load word, full 32 bits, unshifted.
REQ-011 cpu_stall  out  1  pipeline stall (stall_d).
REQ-012 cpu_err  out  1  one-cycle error pulse.
REQ-013 mem_req_valid  out  1  memory request valid.
REQ-014 mem_req_ready  in  1  memory accepts the request.
REQ-015 mem_req_rw  out  1  1 write, 0 read.
REQ-016 mem_req_addr  out  30  word address, cpu_addr[31:2].
REQ-017 mem_req_data  out  32  store data, lane-replicated.
REQ-018 mem_req_mask  out  4  byte write enables.
REQ-019 mem_resp_valid  in  1  read data valid.
REQ-020 mem_resp_data  in  32  read data.

Function
REQ-021 The block SHALL implement states IDLE, REQ, WAIT; cpu_stall SHALL equal (state != IDLE), decoded from registered state only, with no path from cpu_re or cpu_we.
REQ-022 In IDLE with cpu_re|cpu_we high, the block SHALL capture addr, data, mask and rw, then enter REQ on the next edge; with both high, the write SHALL win.
REQ-023 In REQ, mem_req_valid SHALL be 1 and all mem_req_* outputs SHALL remain stable until mem_req_ready is sampled high.
REQ-024 On REQ handshake: a write SHALL go to IDLE; a read SHALL go to WAIT with the timeout counter cleared.
REQ-025 In WAIT, mem_resp_valid high SHALL load cpu_dout with mem_resp_data and return to IDLE on the same edge.
REQ-026 In WAIT, the counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES without a response, the block SHALL:
  - load cpu_dout with 32'hDEAD_BEEF;
  - pulse cpu_err;
  - return to IDLE.
REQ-027 Store mask and data:
  - byte: mask = 1<<addr[1:0], data = {4{din[7:0]}};
  - half: mask = 0011 or 1100 by addr[1], data = {2{din[15:0]}};
  - word: mask = 1111, data = din.
REQ-028 A misaligned store (half with addr[0]=1, or word with addr[1:0]!=0) SHALL be dropped, issue no memory request, pulse cpu_err, and stay in IDLE.
REQ-029 Loads SHALL always use word address addr[31:2]; the caller performs lane extraction.
REQ-030 cpu_dout SHALL hold its value until the next read completes.
REQ-031 mem_resp_valid outside WAIT SHALL be ignored.
REQ-032 Back-to-back: a request present in the IDLE cycle that follows a completion SHALL be accepted in that cycle.

Reset
REQ-033 On reset the block SHALL set:
  - state IDLE, cpu_stall 0, cpu_err 0;
  - mem_req_valid 0, mem_req_rw 0, mem_req_addr 0, mem_req_data 0, mem_req_mask 0;
  - cpu_dout RESET_DOUT, timeout counter 0.
REQ-034 Reset asserted in REQ or WAIT SHALL abandon the transaction: mem_req_valid low after that edge, and any later response ignored.

Configuration
REQ-035 With DCACHE_LINE_BUF_EN defined, the block SHALL hold a one-entry buffer (valid, word address, data), loaded on every completed read.
REQ-036 Buffer read hit in IDLE: no memory request, cpu_dout loaded on the next edge, cpu_stall stays 0.
REQ-037 A store to the buffered word SHALL merge cpu_din bytes by mask into the buffer and still be written to memory.
REQ-038 A timeout SHALL clear the buffer valid bit.
REQ-039 Without DCACHE_LINE_BUF_EN, no buffer logic SHALL exist and every read SHALL go to memory.

Verification
REQ-040 Load at 0x100, ready=1, response after 3 cycles with 0x12345678 -> cpu_stall high 4 cycles; cpu_dout=0x12345678; mem_req_addr=0x40.
REQ-041 Store byte 0xAB at 0x203 -> mask 1000, data 0xABABABAB, rw=1; ready held low 5 cycles -> outputs stable throughout.
REQ-042 Store half at 0x101 -> no mem_req_valid; cpu_err pulses once; cpu_stall 0.
REQ-043 Load with no response, TIMEOUT_CYCLES=4 -> cpu_err pulse after 4 WAIT cycles; cpu_dout=0xDEADBEEF; state IDLE.
REQ-044 DCACHE_LINE_BUF_EN: load 0x100 (0x11223344), store byte 0xFF at 0x100, reload 0x100 -> no memory read; cpu_dout=0x112233FF.
REQ-045 Reset low during WAIT, then response arrives -> mem_req_valid 0; cpu_dout=RESET_DOUT; response ignored.
